// File: rtl/dvp_capture.sv
// DVP camera capture: skips settling frames, packs byte pairs into RGB565 writes.
// Optional DVP_TEST_PATTERN_EN replaces camera data with an x/y gradient.
module dvp_capture #(
  parameter int H_DISP     = 1024,
  parameter int V_DISP     = 768,
  parameter int WAIT_FRAME = 10
) (
  input  logic        cam_pclk,
  input  logic        sys_rst_n,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        wr_en,
  output logic [15:0] wr_data,
  output logic        frame_start,
  output logic        frame_valid,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        line_err
);

  typedef enum logic {S_WAIT, S_CAP} state_t;

  localparam logic [10:0] HL  = 11'(H_DISP);
  localparam logic [10:0] VL  = 11'(V_DISP);
  localparam logic [10:0] SAT = 11'h7FF;
  localparam logic [3:0]  WL  = 4'(WAIT_FRAME - 1);

  state_t      state_q;
  logic        vs_q, vs_prev_q;
  logic        hr_q, hr_prev_q;
  logic [7:0]  data_q, hi_q;
  logic        tog_q;
  logic [3:0]  fcnt_q;
  logic [10:0] xcnt_q, xpos_q, ypos_q;
  logic [15:0] wdata_q;
  logic        wr_en_q, fs_q, fv_q, le_q;

  logic        vs_rise, hr_fall, in_line;
  logic [10:0] xcnt_d, ypos_d;
  logic [15:0] pix_d;

  assign vs_rise = vs_q & ~vs_prev_q;
  // a line only ends if it was open while vsync was low
  assign hr_fall = hr_prev_q & ~hr_q & ~vs_prev_q;
  assign in_line = hr_q & ~vs_q;
  assign xcnt_d  = (xcnt_q == SAT) ? xcnt_q : xcnt_q + 11'd1;
  assign ypos_d  = (ypos_q == SAT) ? ypos_q : ypos_q + 11'd1;

`ifdef DVP_TEST_PATTERN_EN
  assign pix_d = {xcnt_q[7:3], ypos_q[7:2], xcnt_q[7:3]};
`else
  assign pix_d = {hi_q, data_q};
`endif

  always_ff @(posedge cam_pclk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q   <= S_WAIT;
      vs_q      <= 1'b0;
      vs_prev_q <= 1'b0;
      hr_q      <= 1'b0;
      hr_prev_q <= 1'b0;
      data_q    <= 8'd0;
      hi_q      <= 8'd0;
      tog_q     <= 1'b0;
      fcnt_q    <= 4'd0;
      xcnt_q    <= 11'd0;
      xpos_q    <= 11'd0;
      ypos_q    <= 11'd0;
      wdata_q   <= 16'd0;
      wr_en_q   <= 1'b0;
      fs_q      <= 1'b0;
      fv_q      <= 1'b0;
      le_q      <= 1'b0;
    end else begin
      vs_q      <= cam_vsync;
      hr_q      <= cam_href;
      data_q    <= cam_data;
      vs_prev_q <= vs_q;
      hr_prev_q <= hr_q;
      wr_en_q   <= 1'b0;
      fs_q      <= 1'b0;
      le_q      <= 1'b0;
      unique case (state_q)
        S_WAIT: begin
          if (vs_rise) begin
            if (fcnt_q == WL) begin
              fv_q    <= 1'b1;
              fs_q    <= 1'b1;
              state_q <= S_CAP;
            end else begin
              fcnt_q <= fcnt_q + 4'd1;
            end
          end
        end
        S_CAP: begin
          if (!in_line) begin
            tog_q <= 1'b0;
          end else if (!tog_q) begin
            hi_q  <= data_q;
            tog_q <= 1'b1;
          end else begin
            tog_q   <= 1'b0;
            wdata_q <= pix_d;
            wr_en_q <= (xcnt_q < HL) && (ypos_q < VL);
            xpos_q  <= xcnt_q;
            xcnt_q  <= xcnt_d;
          end
          if (hr_fall) begin
            le_q   <= tog_q || (xcnt_q != HL);
            xcnt_q <= 11'd0;
            xpos_q <= 11'd0;
            if (xcnt_q != 11'd0) ypos_q <= ypos_d;
          end
          // frame start wins over a coincident line end
          if (vs_rise) begin
            fs_q   <= 1'b1;
            ypos_q <= 11'd0;
          end
        end
      endcase
    end
  end

  assign wr_en       = wr_en_q;
  assign wr_data     = wdata_q;
  assign frame_start = fs_q;
  assign frame_valid = fv_q;
  assign pixel_xpos  = xpos_q;
  assign pixel_ypos  = ypos_q;
  assign line_err    = le_q;

endmodule

// File: tb/tb_dvp_capture.sv
// Scoreboard bench for dvp_capture (H_DISP=4, V_DISP=2, WAIT_FRAME=2).
module tb_dvp_capture;
  localparam int H = 4;
  localparam int V = 2;
  localparam int W = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        vs = 1'b0;
  logic        hr = 1'b0;
  logic [7:0]  d = 8'd0;
  logic        wr_en, frame_start, frame_valid, line_err;
  logic [15:0] wr_data;
  logic [10:0] pixel_xpos, pixel_ypos;

  dvp_capture #(.H_DISP(H), .V_DISP(V), .WAIT_FRAME(W)) dut (
    .cam_pclk   (clk),
    .sys_rst_n  (rst_n),
    .cam_vsync  (vs),
    .cam_href   (hr),
    .cam_data   (d),
    .wr_en      (wr_en),
    .wr_data    (wr_data),
    .frame_start(frame_start),
    .frame_valid(frame_valid),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .line_err   (line_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] data;
    logic [10:0] x;
    logic [10:0] y;
  } exp_t;

  exp_t sb[$];
  int n_cmp = 0;
  int n_bad = 0;
  int wr_cnt = 0;
  int le_cnt = 0;
  int le_exp = 0;
  int fs_cnt = 0;
  int fs_exp = 0;
  int fs_len = 0;
  int vs_seen = 0;
  int my = 0;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic vsync_pulse();
    @(negedge clk);
    vs = 1'b1;
    step(4);
    vs = 1'b0;
    step(3);
    vs_seen++;
    if (vs_seen >= W) begin
      fs_exp++;
      my = 0;
    end
  endtask

  task automatic send_line(input int nb, input int base);
    int px;
    logic [7:0] hi;
    logic [10:0] xx, yy;
    exp_t e;
    px = 0;
    hi = 8'd0;
    for (int i = 0; i < nb; i++) begin
      @(negedge clk);
      hr = 1'b1;
      d = 8'(base + i);
      if (i % 2 == 0) begin
        hi = d;
      end else begin
        if (vs_seen >= W && px < H && my < V) begin
          xx = 11'(px);
          yy = 11'(my);
`ifdef DVP_TEST_PATTERN_EN
          e.data = {xx[7:3], yy[7:2], xx[7:3]};
`else
          e.data = {hi, d};
`endif
          e.x = xx;
          e.y = yy;
          sb.push_back(e);
        end
        px++;
      end
    end
    @(negedge clk);
    hr = 1'b0;
    d = 8'd0;
    step(4);
    if (vs_seen >= W) begin
      if (px > 0) my++;
      if ((nb % 2 != 0) || px != H) le_exp++;
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (wr_en) begin
        wr_cnt++;
        if (sb.size() == 0) begin
          chk("wr_unexpected", 32'(wr_en), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("wr_data", 32'(wr_data), 32'(e.data));
          chk("xpos", 32'(pixel_xpos), 32'(e.x));
          chk("ypos", 32'(pixel_ypos), 32'(e.y));
        end
      end
      if (line_err) le_cnt++;
      if (frame_start) begin
        fs_len++;
      end else if (fs_len != 0) begin
        chk("fs_width", 32'(fs_len), 32'd1);
        fs_len = 0;
        fs_cnt++;
      end
    end
  end

  task automatic chk_zero(input string pfx);
    chk({pfx, "_wr_en"}, 32'(wr_en), 32'd0);
    chk({pfx, "_wr_data"}, 32'(wr_data), 32'd0);
    chk({pfx, "_fs"}, 32'(frame_start), 32'd0);
    chk({pfx, "_fv"}, 32'(frame_valid), 32'd0);
    chk({pfx, "_xpos"}, 32'(pixel_xpos), 32'd0);
    chk({pfx, "_ypos"}, 32'(pixel_ypos), 32'd0);
    chk({pfx, "_lerr"}, 32'(line_err), 32'd0);
  endtask

  initial begin
    step(2);
    chk_zero("rst");
    rst_n = 1'b1;
    step(2);

    vsync_pulse();
    send_line(8, 1);
    chk("fv_settle1", 32'(frame_valid), 32'd0);
    vsync_pulse();
    chk("fv_settle2", 32'(frame_valid), 32'd1);
    chk("fs_settle", 32'(fs_cnt), 32'(fs_exp));
    chk("wr_settle", 32'(wr_cnt), 32'd0);

    send_line(8, 1);
    send_line(8, 1);
    chk("wr_capture", 32'(wr_cnt), 32'd8);
    chk("le_capture", 32'(le_cnt), 32'(le_exp));

    vsync_pulse();
    send_line(7, 8'h21);
    chk("le_odd", 32'(le_cnt), 32'(le_exp));
    send_line(8, 8'h31);
    chk("wr_odd", 32'(wr_cnt), 32'd15);

    vsync_pulse();
    send_line(12, 8'h41);
    chk("le_clip", 32'(le_cnt), 32'(le_exp));
    for (int k = 0; k < 3; k++) send_line(8, 8'h61 + 8 * k);
    chk("wr_clip", 32'(wr_cnt), 32'd23);

    @(negedge clk);
    hr = 1'b1;
    d = 8'h11;
    @(negedge clk);
    d = 8'h22;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_zero("midrst");
    hr = 1'b0;
    d = 8'd0;
    sb.delete();
    vs_seen = 0;
    my = 0;
    fs_len = 0;
    step(2);
    rst_n = 1'b1;
    step(2);

    send_line(8, 1);
    vsync_pulse();
    send_line(8, 1);
    chk("fv_rst1", 32'(frame_valid), 32'd0);
    chk("wr_rst1", 32'(wr_cnt), 32'd23);
    vsync_pulse();
    chk("fv_rst2", 32'(frame_valid), 32'd1);
    send_line(8, 8'h51);
    chk("wr_resume", 32'(wr_cnt), 32'd27);

    step(10);
    chk("sb_empty", 32'(sb.size()), 32'd0);
    chk("fs_total", 32'(fs_cnt), 32'(fs_exp));
    chk("le_total", 32'(le_cnt), 32'(le_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
